// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues req/ack reads at pc_curr, drives PCWrite,
// and owns the IF/ID register. A one-entry hold buffer parks a word that
// arrived while ID was stalled, so nothing is lost or fetched twice.
module if_fetch_unit #(
    parameter int unsigned     WORD  = 32,
    parameter logic [WORD-1:0] NOP   = '0,
    parameter int unsigned     CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WORD-1:0]  pc_curr,
    output logic             pc_write,
    output logic             imem_req,
    output logic [WORD-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [WORD-1:0]  imem_rdata,
    input  logic             id_stall,
    input  logic             flush,
    output logic [WORD-1:0]  ifid_instr,
    output logic [WORD-1:0]  ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e           state_q;
    logic [WORD-1:0]  hold_instr_q;
    logic [WORD-1:0]  hold_pc4_q;
    logic [WORD-1:0]  ifid_instr_q;
    logic [WORD-1:0]  ifid_pc4_q;
    logic             ifid_valid_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic [WORD-1:0]  pc_plus4;
    logic             fetching;
    logic             bubble;
    logic             cnt_max;

    // PC+4 wraps modulo 2^WORD; bubbles come from flushes or unacked fetches into a free ID.
    always_comb begin
        pc_plus4 = pc_curr + WORD'(4);
        fetching = (state_q == StFetch);
        bubble   = flush | (fetching & ~imem_ack & ~id_stall);
        cnt_max  = &bubble_cnt_q;
    end

    // Handshake outputs; both forced low while reset is asserted.
    always_comb begin
        imem_addr = pc_curr;
        imem_req  = rst_n & fetching;
        pc_write  = rst_n & (flush | (fetching & imem_ack));
    end

    // FSM, hold buffer, IF/ID register and saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            hold_instr_q <= NOP;
            hold_pc4_q   <= '0;
            ifid_instr_q <= NOP;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            if (bubble && !cnt_max) begin
                bubble_cnt_q <= bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                // Redirect: drop both the incoming word and anything parked.
                state_q      <= StFetch;
                hold_instr_q <= NOP;
                hold_pc4_q   <= '0;
                ifid_instr_q <= NOP;
                ifid_pc4_q   <= '0;
                ifid_valid_q <= 1'b0;
            end else if (fetching) begin
                if (imem_ack && !id_stall) begin
                    ifid_instr_q <= imem_rdata;
                    ifid_pc4_q   <= pc_plus4;
                    ifid_valid_q <= 1'b1;
                end else if (imem_ack) begin
                    // PC already moved past this word, so it must be parked.
                    hold_instr_q <= imem_rdata;
                    hold_pc4_q   <= pc_plus4;
                    state_q      <= StHold;
                end else if (!id_stall) begin
                    ifid_instr_q <= NOP;
                    ifid_pc4_q   <= '0;
                    ifid_valid_q <= 1'b0;
                end
            end else if (!id_stall) begin
                ifid_instr_q <= hold_instr_q;
                ifid_pc4_q   <= hold_pc4_q;
                ifid_valid_q <= 1'b1;
                state_q      <= StFetch;
            end
        end
    end

    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written reset
// sequence, then random traffic against a queue-based reference model.
// A second instance with a 2-bit counter shares all inputs to exercise
// bubble counter saturation.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_curr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;

    logic        pc_write, imem_req, ifid_valid;
    logic [31:0] imem_addr, ifid_instr, ifid_pc4;
    logic [15:0] bubble_cnt;

    logic        s_pc_write, s_imem_req, s_ifid_valid;
    logic [31:0] s_imem_addr, s_ifid_instr, s_ifid_pc4;
    logic [1:0]  s_bubble_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.WORD(32), .NOP(32'h0), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_curr    (pc_curr),
        .pc_write   (pc_write),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_stall   (id_stall),
        .flush      (flush),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .bubble_cnt (bubble_cnt)
    );

    if_fetch_unit #(.WORD(32), .NOP(32'h0), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_curr    (pc_curr),
        .pc_write   (s_pc_write),
        .imem_req   (s_imem_req),
        .imem_addr  (s_imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_stall   (id_stall),
        .flush      (flush),
        .ifid_instr (s_ifid_instr),
        .ifid_pc4   (s_ifid_pc4),
        .ifid_valid (s_ifid_valid),
        .bubble_cnt (s_bubble_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                         input logic stall, input logic fl);
        pc_curr    = pc;
        imem_ack   = ack;
        imem_rdata = rd;
        id_stall   = stall;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int c);
        return (c > 3) ? 3 : c;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        fl;
        logic        pcw;
        logic        req;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        int          cnt;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                                input logic stall, input logic fl, input logic pcw,
                                input logic req, input logic valid, input logic [31:0] instr,
                                input logic [31:0] pc4, input int cnt);
        vec_t v;
        v.pc = pc; v.ack = ack; v.rdata = rd; v.stall = stall; v.fl = fl;
        v.pcw = pcw; v.req = req; v.valid = valid; v.instr = instr; v.pc4 = pc4; v.cnt = cnt;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      hold_q[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    int          m_cnt;

    task automatic model_reset();
        hold_q.delete();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_cnt   = 0;
    endtask

    // One clock of the reference: check handshake before the edge, IF/ID after it.
    task automatic model_cycle();
        logic   parked;
        logic   e_req, e_pcw;
        entry_t e;
        parked = (hold_q.size() != 0);
        e_req  = !parked;
        e_pcw  = flush || (!parked && imem_ack);
        #3;
        chk("m_imem_req", 32'(imem_req), 32'(e_req));
        chk("m_pc_write", 32'(pc_write), 32'(e_pcw));
        chk("m_imem_addr", imem_addr, pc_curr);
        if (flush) begin
            hold_q.delete();
            m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt++;
        end else if (parked) begin
            if (!id_stall) begin
                e = hold_q.pop_front();
                m_valid = 1'b1; m_instr = e.instr; m_pc4 = e.pc4;
            end
        end else if (imem_ack) begin
            e.instr = imem_rdata;
            e.pc4   = pc_curr + 32'd4;
            if (id_stall) hold_q.push_back(e);
            else begin
                m_valid = 1'b1; m_instr = e.instr; m_pc4 = e.pc4;
            end
        end else if (!id_stall) begin
            m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt++;
        end
        tick();
        chk("m_ifid_valid", 32'(ifid_valid), 32'(m_valid));
        chk("m_ifid_instr", ifid_instr, m_instr);
        chk("m_ifid_pc4", ifid_pc4, m_pc4);
        chk("m_bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
        chk("m_sat_cnt", 32'(s_bubble_cnt), 32'(sat3(m_cnt)));
    endtask

    initial begin
        tbl[0]  = mk(32'h00, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 32'h04, 0);
        tbl[1]  = mk(32'h04, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 32'h08, 0);
        tbl[2]  = mk(32'h08, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, 32'h0C, 0);
        tbl[3]  = mk(32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 1);
        tbl[4]  = mk(32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 2);
        tbl[5]  = mk(32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 3);
        tbl[6]  = mk(32'h10, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h14, 3);
        // ack while stalled: word parked, IF/ID untouched
        tbl[7]  = mk(32'h20, 1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h14, 3);
        tbl[8]  = mk(32'h24, 1'b1, 32'h0BAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h14, 3);
        tbl[9]  = mk(32'h24, 1'b1, 32'h0BAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF, 32'h24, 3);
        tbl[10] = mk(32'h30, 1'b1, 32'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5555, 32'h34, 3);
        tbl[11] = mk(32'h20, 1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5555, 32'h34, 3);
        // flush in HOLD: parked 0xBEEF discarded
        tbl[12] = mk(32'h24, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00, 4);
        tbl[13] = mk(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 5);
        // flush beats ack and stall together
        tbl[14] = mk(32'h50, 1'b1, 32'h7777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 32'h00, 6);
        tbl[15] = mk(32'hFFFF_FFFC, 1'b1, 32'h9999, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h9999,
                     32'h0, 6);

        // Reset state, with ack and flush asserted to show the handshake is gated.
        rst_n = 1'b0;
        drive(32'h100, 1'b1, 32'hFFFF, 1'b0, 1'b1);
        #2;
        chk("rst_pc_write", 32'(pc_write), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_ifid_valid", 32'(ifid_valid), 32'h0);
        chk("rst_ifid_instr", ifid_instr, 32'h0);
        chk("rst_ifid_pc4", ifid_pc4, 32'h0);
        chk("rst_bubble_cnt", 32'(bubble_cnt), 32'h0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].pc, tbl[i].ack, tbl[i].rdata, tbl[i].stall, tbl[i].fl);
            #3;
            chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
            chk($sformatf("v%0d_imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("v%0d_imem_addr", i), imem_addr, tbl[i].pc);
            tick();
            chk($sformatf("v%0d_ifid_valid", i), 32'(ifid_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d_ifid_instr", i), ifid_instr, tbl[i].instr);
            chk($sformatf("v%0d_ifid_pc4", i), ifid_pc4, tbl[i].pc4);
            chk($sformatf("v%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_sat_cnt", i), 32'(s_bubble_cnt), 32'(sat3(tbl[i].cnt)));
        end

        // Asynchronous reset while parked in HOLD with a valid IF/ID.
        drive(32'h60, 1'b1, 32'hCAFE, 1'b0, 1'b0);
        tick();
        chk("ar_pre_valid", 32'(ifid_valid), 32'h1);
        chk("ar_pre_instr", ifid_instr, 32'hCAFE);
        drive(32'h64, 1'b1, 32'hD00D, 1'b1, 1'b0);
        tick();
        chk("ar_hold_instr", ifid_instr, 32'hCAFE);
        drive(32'h68, 1'b1, 32'h0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(ifid_valid), 32'h0);
        chk("ar_instr", ifid_instr, 32'h0);
        chk("ar_pc4", ifid_pc4, 32'h0);
        chk("ar_bubble_cnt", 32'(bubble_cnt), 32'h0);
        chk("ar_sat_cnt", 32'(s_bubble_cnt), 32'h0);
        chk("ar_pc_write", 32'(pc_write), 32'h0);
        chk("ar_imem_req", 32'(imem_req), 32'h0);
        tick();
        rst_n = 1'b1;
        model_reset();

        // After reset the parked 0xD00D must be gone and fetching resumed.
        drive(32'h70, 1'b1, 32'h1111, 1'b0, 1'b0);
        model_cycle();

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            drive(pc, $urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and issues a request/acknowledge read to instruction memory.
- Drives the PC register's write enable (PCWrite) and owns the IF/ID pipeline register: instruction, PC+4 and valid bit.
- Absorbs decode-stage stalls, branch flushes and variable memory latency; counts bubbles injected into ID.

Parameters:
- WORD, 32, datapath/address width.
- NOP, 32'h0000_0000, instruction word loaded into IF/ID on bubble or flush.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- pc_curr  input  WORD  current PC (from the PC register's curr).
- pc_write  output  1  PCWrite to the PC register; combinational.
- imem_req  output  1  instruction memory read request; combinational.
- imem_addr  output  WORD  read address; always equals pc_curr.
- imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1.
- imem_rdata  input  WORD  instruction word, valid when imem_ack=1.
- id_stall  input  1  hazard unit: ID cannot accept a new instruction; IF/ID must hold.
- flush  input  1  branch/jump taken; discard the fetched/held instruction; PC loads the redirect target.
- ifid_instr  output  WORD  registered instruction to ID.
- ifid_pc4  output  WORD  registered PC+4 of that instruction.
- ifid_valid  output  1  registered; 1 means ifid_instr is a real instruction.
- bubble_cnt  output  CNT_W  registered count of bubbles written into IF/ID.

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH, ifid_instr=NOP, ifid_pc4=0, ifid_valid=0, hold buffer empty, bubble_cnt=0. pc_write=0 and imem_req=0 while rst_n=0.
- State FETCH: imem_req=1, imem_addr=pc_curr.
  - ack=1, id_stall=0: on the clock edge IF/ID <= {imem_rdata, pc_curr+4, valid=1}. pc_write=1 that cycle. Stay in FETCH.
  - ack=1, id_stall=1: hold_instr <= imem_rdata, hold_pc4 <= pc_curr+4. pc_write=1 (PC advances past the captured word). IF/ID unchanged. Go to HOLD.
  - ack=0, id_stall=0: IF/ID <= {NOP, 0, valid=0}, bubble_cnt increments. pc_write=0.
  - ack=0, id_stall=1: IF/ID unchanged, pc_write=0.
- State HOLD: imem_req=0, pc_write=0.
  - id_stall=1: hold everything.
  - id_stall=0: IF/ID <= {hold_instr, hold_pc4, valid=1}. Go to FETCH.
- flush=1 has highest priority in any state:
  - IF/ID <= {NOP, 0, valid=0}, bubble_cnt increments.
  - Hold buffer discarded; state <= FETCH.
  - pc_write=1 so the PC register loads the externally muxed target.
  - Any imem_ack in the same cycle is ignored.
  - flush overrides id_stall.
- Latency: a word acked in cycle N appears on ifid_instr in cycle N+1. With zero-wait memory (ack every cycle) throughput is 1 instruction/cycle.
- Abandoned requests: memory must tolerate imem_addr changing while unacked (after flush). No outstanding-transaction tracking is required.
- Arithmetic: pc_curr+4 is modulo 2^WORD (0xFFFF_FFFC+4 = 0).
- bubble_cnt saturates at 2^CNT_W-1 and never wraps.
- No instruction is lost or duplicated across stall/HOLD sequences.
- Reset mid-HOLD or mid-request returns to FETCH with IF/ID invalid.

Test Plan:
- Reset, then pc_curr=0x00, 0x04, 0x08 with ack=1 every cycle, rdata=0xA0,0xA1,0xA2 -> ifid_instr=0xA0,0xA1,0xA2 and ifid_pc4=0x04,0x08,0x0C on consecutive cycles; pc_write=1 continuously; bubble_cnt=0.
- pc_curr=0x10, ack held low 3 cycles then ack=1 with rdata=0x1234 -> pc_write=0 for 3 cycles; 3 bubbles (valid=0, instr=NOP); bubble_cnt=3; then ifid_instr=0x1234, ifid_pc4=0x14.
- ack=1 rdata=0xBEEF at pc_curr=0x20 while id_stall=1 for 2 cycles -> HOLD entered, imem_req=0, IF/ID unchanged; on id_stall=0, ifid_instr=0xBEEF, ifid_pc4=0x24 exactly once.
- In HOLD with 0xBEEF held, assert flush=1 -> ifid_valid=0, ifid_instr=NOP, pc_write=1, state FETCH; 0xBEEF never appears on ifid_instr.
- flush=1 together with ack=1 and id_stall=1 -> flush wins: IF/ID bubble, pc_write=1, rdata discarded; pc_curr=0xFFFF_FFFC acked next -> ifid_pc4=0x0.
- Assert rst_n=0 asynchronously mid-stall with ifid_valid=1 -> outputs reset immediately without a clock edge; bubble counter saturation checked with CNT_W=2: 5 bubbles -> bubble_cnt=3.
